// File: rtl/gray_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
// Shared definitions for the Gray-code counter and its checkers.
//  - step_kind_e : what the counter does on a given edge
//  - DEF_WIDTH / DEF_MAX : default counter width and its largest value
//  - bin2gray / gray2bin : width-agnostic conversions on a 64-bit container.
//    Callers zero-extend narrower values and truncate the result. Zero upper
//    bits leave the low bits of either conversion correct.
// -----------------------------------------------------------------------------
package gray_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_MAX   = 2**DEF_WIDTH - 1;

    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_LOAD = 2'd1,
        STEP_INC  = 2'd2,
        STEP_DEC  = 2'd3
    } step_kind_e;

    function automatic logic [63:0] bin2gray(input logic [63:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [63:0] gray2bin(input logic [63:0] gray);
        logic [63:0] bin;
        bin[63] = gray[63];
        for (int i = 62; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/binary2gray.sv
// -----------------------------------------------------------------------------
// binary2gray
// Purely combinational binary-to-Gray converter.
// Ports:
//  bin   in  WIDTH  binary value
//  gray  out WIDTH  Gray encoding of bin (bin ^ (bin >> 1))
// -----------------------------------------------------------------------------
module binary2gray #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    // The MSB passes straight through; every lower bit is the XOR of itself
    // and its upper neighbour.
    assign gray[WIDTH-1] = bin[WIDTH-1];

    generate
        for (genvar gi = 0; gi < WIDTH-1; gi++) begin : g_bit
            assign gray[gi] = bin[gi] ^ bin[gi+1];
        end
    endgenerate

endmodule

// File: rtl/gray_counter.sv
// -----------------------------------------------------------------------------
// gray_counter
// Registered up/down binary counter with a registered Gray-code twin output.
// Each enabled step changes exactly one Gray bit; load may change several.
// Ports:
//  clk       in   1      rising-edge clock
//  rst       in   1      asynchronous active-high reset (to INIT)
//  en        in   1      advance one step this cycle
//  up_dn     in   1      1 = increment, 0 = decrement
//  load      in   1      synchronous load of load_val (beats en)
//  load_val  in   WIDTH  binary value to load
//  bin_out   out  WIDTH  current count, binary
//  gray_out  out  WIDTH  current count, Gray
//  wrap      out  1      one-cycle pulse after a limit crossing (max->0, 0->max)
//  at_limit  out  1      count sits at the limit in the current up_dn direction
// Parameters:
//  WIDTH      counter width, >= 2
//  INIT       reset value, < 2**WIDTH
//  WRAP_MODE  1 = wrap at limits, 0 = saturate at limits
// -----------------------------------------------------------------------------
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int INIT      = 0,
    parameter bit WRAP_MODE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_VAL   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] INIT_VAL  = INIT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] INIT_GRAY = WIDTH'(bin2gray(64'(INIT_VAL)));

    logic [WIDTH-1:0] bin_reg;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_reg;
    logic [WIDTH-1:0] gray_next;
    logic             wrap_reg;
    logic             wrap_next;
    logic             at_max;
    logic             at_zero;
    step_kind_e       step_kind;

    assign at_max  = (bin_reg == MAX_VAL);
    assign at_zero = (bin_reg == '0);

    // Priority below reset: load, then en, then hold.
    always_comb begin
        step_kind = STEP_HOLD;
        if (load) begin
            step_kind = STEP_LOAD;
        end else if (en) begin
            step_kind = up_dn ? STEP_INC : STEP_DEC;
        end
    end

    // Next binary value and wrap pulse. At a limit the count either wraps
    // (with a one-cycle pulse) or holds, depending on WRAP_MODE.
    always_comb begin
        bin_next  = bin_reg;
        wrap_next = 1'b0;
        case (step_kind)
            STEP_LOAD: begin
                bin_next = load_val;
            end
            STEP_INC: begin
                if (!at_max) begin
                    bin_next = bin_reg + ONE_VAL;
                end else if (WRAP_MODE) begin
                    bin_next  = '0;
                    wrap_next = 1'b1;
                end
            end
            STEP_DEC: begin
                if (!at_zero) begin
                    bin_next = bin_reg - ONE_VAL;
                end else if (WRAP_MODE) begin
                    bin_next  = MAX_VAL;
                    wrap_next = 1'b1;
                end
            end
            default: begin
                bin_next = bin_reg;
            end
        endcase
    end

    // Gray is encoded from the next binary value and registered alongside it,
    // so gray_out is glitch-free and lands on the same edge as bin_out.
    binary2gray #(
        .WIDTH (WIDTH)
    ) u_binary2gray (
        .bin  (bin_next),
        .gray (gray_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_reg  <= INIT_VAL;
            gray_reg <= INIT_GRAY;
            wrap_reg <= 1'b0;
        end else begin
            bin_reg  <= bin_next;
            gray_reg <= gray_next;
            wrap_reg <= wrap_next;
        end
    end

    assign bin_out  = bin_reg;
    assign gray_out = gray_reg;
    assign wrap     = wrap_reg;
    // Deliberately combinational on up_dn so a consumer can see the limit in
    // the cycle before the edge that would cross it.
    assign at_limit = up_dn ? at_max : at_zero;

endmodule

// File: tb/tb_gray_counter.sv
module tb_gray_counter;
    import gray_pkg::*;

    localparam int W    = 4;
    localparam int MAXV = 2**W - 1;

    logic         clk      = 1'b0;
    logic         rst      = 1'b0;
    logic         en       = 1'b0;
    logic         up_dn    = 1'b1;
    logic         load     = 1'b0;
    logic [W-1:0] load_val = '0;

    logic [W-1:0] bin_w, gray_w, bin_s, gray_s;
    logic         wrap_w, at_limit_w, wrap_s, at_limit_s;

    int total = 0;
    int bad   = 0;

    // Behavioural reference: plain integer counts, one per instance.
    int m_w = 0;
    int m_s = 0;
    bit mw_wrap = 1'b0;
    bit ms_wrap = 1'b0;

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(W), .INIT(0), .WRAP_MODE(1'b1)) dut_w (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .bin_out(bin_w), .gray_out(gray_w),
        .wrap(wrap_w), .at_limit(at_limit_w)
    );

    gray_counter #(.WIDTH(W), .INIT(0), .WRAP_MODE(1'b0)) dut_s (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .bin_out(bin_s), .gray_out(gray_s),
        .wrap(wrap_s), .at_limit(at_limit_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_edge(inout int cnt, inout bit wr, input bit wrap_mode);
        wr = 1'b0;
        if (load) begin
            cnt = int'(load_val);
        end else if (en) begin
            if (up_dn) begin
                if (cnt < MAXV) cnt = cnt + 1;
                else if (wrap_mode) begin cnt = 0; wr = 1'b1; end
            end else begin
                if (cnt > 0) cnt = cnt - 1;
                else if (wrap_mode) begin cnt = MAXV; wr = 1'b1; end
            end
        end
    endfunction

    task automatic model_reset();
        m_w = 0; m_s = 0; mw_wrap = 1'b0; ms_wrap = 1'b0;
    endtask

    task automatic check_all();
        chk("w_bin",      32'(bin_w),  32'(m_w));
        chk("w_gray",     32'(gray_w), 32'(bin2gray(64'(m_w))));
        chk("w_gray_rel", 32'(gray_w), 32'(bin2gray(64'(bin_w))));
        chk("w_gray2bin", 32'(gray2bin(64'(gray_w))), 32'(m_w));
        chk("w_wrap",     32'(wrap_w), 32'(mw_wrap));
        chk("w_at_limit", 32'(at_limit_w), 32'(up_dn ? (m_w == MAXV) : (m_w == 0)));
        chk("s_bin",      32'(bin_s),  32'(m_s));
        chk("s_gray",     32'(gray_s), 32'(bin2gray(64'(m_s))));
        chk("s_wrap",     32'(wrap_s), 32'(ms_wrap));
        chk("s_at_limit", 32'(at_limit_s), 32'(up_dn ? (m_s == MAXV) : (m_s == 0)));
    endtask

    // One clock edge: advance the model with the inputs the DUT sampled,
    // then compare just after the edge.
    task automatic step();
        logic [W-1:0] prev_gray;
        int           prev_cnt;
        bit           counted;
        prev_gray = gray_w;
        prev_cnt  = m_w;
        counted   = !rst && !load && en;
        @(posedge clk);
        if (rst) model_reset();
        else begin
            model_edge(m_w, mw_wrap, 1'b1);
            model_edge(m_s, ms_wrap, 1'b0);
        end
        #1;
        check_all();
        if (counted && (m_w != prev_cnt))
            chk("w_hamming", 32'($countones(prev_gray ^ gray_w)), 32'd1);
    endtask

    int gseq [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    initial begin
        // Asynchronous reset: values must appear before any clock edge.
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        step();
        step();
        @(negedge clk);
        rst = 1'b0; en = 1'b1; up_dn = 1'b1;

        // 1. Full up-count through the Gray sequence.
        for (int i = 0; i < 16; i++) begin
            chk("t1_gray_seq", 32'(gray_w), 32'(gseq[i]));
            step();
        end
        // 2. 15 -> 0 wrap pulse, then it drops.
        chk("t2_bin", 32'(bin_w), 32'd0);
        chk("t2_wrap", 32'(wrap_w), 32'd1);
        en = 1'b0;
        step();
        chk("t2_wrap_drop", 32'(wrap_w), 32'd0);

        // 3. Down from 0 wraps to 15; at_limit visible before the edge.
        en = 1'b1; up_dn = 1'b0;
        #1;
        chk("t3_at_limit", 32'(at_limit_w), 32'd1);
        step();
        chk("t3_bin", 32'(bin_w), 32'd15);
        chk("t3_gray", 32'(gray_w), 32'h8);
        chk("t3_wrap", 32'(wrap_w), 32'd1);

        // 4. Load beats en, then counting resumes from the loaded value.
        load = 1'b1; load_val = 4'd9; en = 1'b1; up_dn = 1'b1;
        step();
        chk("t4_load_gray", 32'(gray_w), 32'hD);
        chk("t4_load_wrap", 32'(wrap_w), 32'd0);
        load = 1'b0;
        step();
        chk("t4_next_bin", 32'(bin_w), 32'd10);
        chk("t4_next_gray", 32'(gray_w), 32'hF);

        // 5. Saturating instance holds at 15.
        load = 1'b1; load_val = 4'd15;
        step();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_sat_bin", 32'(bin_s), 32'd15);
            chk("t5_sat_gray", 32'(gray_s), 32'h8);
            chk("t5_sat_wrap", 32'(wrap_s), 32'd0);
            chk("t5_sat_at_limit", 32'(at_limit_s), 32'd1);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            load     = ($urandom_range(0, 9) == 0);
            load_val = W'($urandom);
            en       = ($urandom_range(0, 3) != 0);
            up_dn    = 1'($urandom);
            step();
        end

        // 6. Reset between edges abandons the count at once.
        load = 1'b1; load_val = 4'd6; en = 1'b1; up_dn = 1'b1;
        step();
        load = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("t6_rst_gray", 32'(gray_w), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("t6_first_gray", 32'(gray_w), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
